// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART transmitter.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_mode_e;

  // Widest legal frame payload; parity is computed on a zero-extended copy.
  localparam int unsigned MAX_DATA_WIDTH = 9;

  // The unused encoding 3 behaves exactly like "no parity".
  function automatic parity_mode_e decode_parity(input logic [1:0] mode);
    parity_mode_e m;
    m = PAR_NONE;
    if (mode == 2'd1) begin
      m = PAR_EVEN;
    end else if (mode == 2'd2) begin
      m = PAR_ODD;
    end
    return m;
  endfunction

  // Even: XOR of data bits. Odd: its inverse.
  function automatic logic calc_parity(input logic [MAX_DATA_WIDTH-1:0] data,
                                       input parity_mode_e mode);
    logic p;
    p = ^data;
    if (mode == PAR_ODD) begin
      p = ~p;
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with occupancy count and a look-ahead (fall-through) head word.
// Latency: a word written on edge k is visible at rd_data_o after edge k.
// Backpressure: writes ignored while full_o, reads ignored while empty_o.
// Ports: clk_i/reset_i (sync, active-high), wr_en_i/wr_data_i, rd_en_i/rd_data_o,
//        full_o, empty_o, count_o (0..DEPTH).
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
  localparam logic [AW:0] ONE_CNT  = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             do_wr, do_rd;

  assign full_o    = (count_q == FULL_CNT);
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  assign do_wr = wr_en_i && !full_o;
  assign do_rd = rd_en_i && !empty_o;

  // Simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with input FIFO, selectable parity and one/two stop bits.
// Latency: word accepted on edge k drives the start bit from edge k+2 (idle FIFO/FSM).
// Backpressure: tx_ready = !full; frames run back-to-back while the FIFO holds data.
// Ports: clk, reset (sync, active-high), tx_data/tx_valid/tx_ready (write side),
//        parity_mode (0 none, 1 even, 2 odd, 3 none), two_stop, TxD (idle high),
//        busy (frame in flight or FIFO non-empty), fifo_count.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [1:0]            parity_mode,
  input  logic                  two_stop,
  output logic                  TxD,
  output logic                  busy,
  output logic [CW-1:0]         fifo_count
);

  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int BW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [BW-1:0] LAST_CYC = BW'(CPB - 1);
  localparam logic [3:0]    LAST_BIT = 4'(DATA_WIDTH - 1);

  tx_state_e             state_q, state_d;
  logic [BW-1:0]         cyc_q, cyc_d;
  logic [3:0]            bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_bit_q, par_bit_d;
  logic                  par_en_q, par_en_d;
  logic                  two_stop_q, two_stop_d;
  logic                  txd_q, txd_d;

  logic                  pop;
  logic                  bit_end;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_full, fifo_empty;
  parity_mode_e          mode_in;

  uart_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk),
    .reset_i   (reset),
    .wr_en_i   (tx_valid),
    .wr_data_i (tx_data),
    .rd_en_i   (pop),
    .rd_data_o (fifo_rdata),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  assign tx_ready = !fifo_full;
  assign busy     = (state_q != ST_IDLE) || (fifo_count != '0);
  assign TxD      = txd_q;
  assign mode_in  = decode_parity(parity_mode);
  assign bit_end  = (cyc_q == LAST_CYC);

  always_comb begin
    state_d    = state_q;
    cyc_d      = bit_end ? '0 : cyc_q + BW'(1);
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    par_en_d   = par_en_q;
    two_stop_d = two_stop_q;
    txd_d      = 1'b1;
    pop        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cyc_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        txd_d = 1'b0;
        if (bit_end) begin
          bit_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        txd_d = shift_q[0];
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == LAST_BIT) begin
            bit_d   = '0;
            state_d = par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        txd_d = par_bit_q;
        if (bit_end) begin
          bit_d   = '0;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          // bit_q counts stop bits already sent when two are requested.
          if (two_stop_q && (bit_q == '0)) begin
            bit_d = 4'd1;
          end else begin
            bit_d = '0;
            if (!fifo_empty) begin
              pop     = 1'b1;
              state_d = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Frame setup is captured with the pop so mid-frame input changes only
    // affect the following frame.
    if (pop) begin
      shift_d    = fifo_rdata;
      par_en_d   = (mode_in != PAR_NONE);
      par_bit_d  = calc_parity(MAX_DATA_WIDTH'(fifo_rdata), mode_in);
      two_stop_d = two_stop;
    end
  end

  // TxD is registered from the state, so each line bit appears one edge
  // after its state is entered; every bit keeps the full CPB duration.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cyc_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      par_en_q   <= 1'b0;
      two_stop_q <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      par_en_q   <= par_en_d;
      two_stop_q <= two_stop_d;
      txd_q      <= txd_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: 8-bit and 5-bit instances at 10 clocks per bit.
// Latency: n/a.
// Backpressure: pushes wait on tx_ready with a bounded loop.
module tb_uart_tx_cfg;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [1:0] parity_mode;
  logic       two_stop;
  logic       TxD, busy;
  logic [4:0] fifo_count;

  logic [4:0] tx_data5;
  logic       tx_valid5, tx_ready5, TxD5, busy5;
  logic [4:0] fifo_count5;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_cfg #(
    .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_WIDTH(8), .FIFO_DEPTH(16)
  ) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .parity_mode(parity_mode), .two_stop(two_stop),
    .TxD(TxD), .busy(busy), .fifo_count(fifo_count)
  );

  uart_tx_cfg #(
    .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_WIDTH(5), .FIFO_DEPTH(16)
  ) dut5 (
    .clk(clk), .reset(reset), .tx_data(tx_data5), .tx_valid(tx_valid5),
    .tx_ready(tx_ready5), .parity_mode(parity_mode), .two_stop(two_stop),
    .TxD(TxD5), .busy(busy5), .fifo_count(fifo_count5)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic line_of(input bit sel);
    return sel ? TxD5 : TxD;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic [7:0] d);
    int t;
    tx_data  = d;
    tx_valid = 1'b1;
    t = 0;
    while (!tx_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) check_val("push_ready", 32'(tx_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Finds the start bit, then checks that each bit holds its level for CPB cycles.
  task automatic capture(input string tag, input bit sel, input int nbits,
                         input logic [15:0] exp_bits, input bit contiguous);
    bit   found;
    bit   same;
    logic v;
    if (contiguous) check_val({tag, "_contig"}, 32'(line_of(sel)), 32'd0);
    found = 1'b0;
    for (int t = 0; t < 600; t++) begin
      if (line_of(sel) == 1'b0) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_val({tag, "_start"}, 32'(found), 32'd1);
    if (found) begin
      check_val({tag, "_busy"}, 32'(sel ? busy5 : busy), 32'd1);
      for (int b = 0; b < nbits; b++) begin
        v    = line_of(sel);
        same = 1'b1;
        for (int c = 0; c < CPB; c++) begin
          if (line_of(sel) !== v) same = 1'b0;
          @(negedge clk);
        end
        check_val($sformatf("%s_bit%0d", tag, b), same ? 32'(v) : 32'd2, 32'(exp_bits[b]));
      end
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    reset = 1'b1; tx_valid = 1'b0; tx_data = '0; tx_valid5 = 1'b0; tx_data5 = '0;
    parity_mode = 2'd0; two_stop = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_txd",   32'(TxD), 32'd1);
    check_val("rst_busy",  32'(busy), 32'd0);
    check_val("rst_count", 32'(fifo_count), 32'd0);
    check_val("rst_ready", 32'(tx_ready), 32'd1);
    check_val("rst_txd5",  32'(TxD5), 32'd1);
    check_val("rst_ready5", 32'(tx_ready5), 32'd1);
    reset = 1'b0;
    @(negedge clk);

    // 0xA5, even parity, one stop; start bit exactly two edges after accept.
    parity_mode = 2'd1; two_stop = 1'b0;
    tx_data = 8'hA5; tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    check_val("lat_k_count", 32'(fifo_count), 32'd1);
    check_val("lat_k_txd",   32'(TxD), 32'd1);
    check_val("lat_k_busy",  32'(busy), 32'd1);
    @(negedge clk);
    check_val("lat_k1_txd",   32'(TxD), 32'd1);
    check_val("lat_k1_count", 32'(fifo_count), 32'd0);
    @(negedge clk);
    check_val("lat_k2_txd", 32'(TxD), 32'd0);
    capture("a5", 1'b0, 11, 16'h054A, 1'b0);
    check_val("a5_end_busy", 32'(busy), 32'd0);
    check_val("a5_end_txd",  32'(TxD), 32'd1);

    // 0x00, odd parity, two stop bits.
    parity_mode = 2'd2; two_stop = 1'b1;
    push(8'h00);
    capture("z00", 1'b0, 12, 16'h0E00, 1'b0);
    check_val("z00_end_busy", 32'(busy), 32'd0);

    // Parity switched from even to none while frame 1 is in DATA.
    parity_mode = 2'd1; two_stop = 1'b0;
    push(8'h01);
    push(8'h03);
    fork
      begin
        capture("pm1", 1'b0, 11, 16'h0602, 1'b0);
        capture("pm2", 1'b0, 10, 16'h0206, 1'b1);
      end
      begin
        repeat (30) @(negedge clk);
        parity_mode = 2'd0;
      end
    join
    check_val("pm_end_busy", 32'(busy), 32'd0);

    // 17 back-to-back pushes into a 16-deep FIFO, then a held push while full.
    parity_mode = 2'd0; two_stop = 1'b0;
    fork
      begin
        for (int i = 0; i < 17; i++) push(8'(16 + i));
        check_val("full_count", 32'(fifo_count), 32'd16);
        check_val("full_ready", 32'(tx_ready), 32'd0);
        tx_data = 8'hFF; tx_valid = 1'b1;
        repeat (3) @(negedge clk);
        check_val("full_hold_count", 32'(fifo_count), 32'd16);
        tx_valid = 1'b0;
      end
      begin
        for (int f = 0; f < 17; f++)
          capture($sformatf("bb%0d", f), 1'b0, 10, {6'b0, 1'b1, 8'(16 + f), 1'b0}, f != 0);
      end
    join
    check_val("bb_end_busy",  32'(busy), 32'd0);
    check_val("bb_end_count", 32'(fifo_count), 32'd0);

    // Reset during data bit 3 with four words queued.
    for (int i = 0; i < 5; i++) push(8'h55);
    repeat (40) @(negedge clk);
    check_val("rst_pre_count", 32'(fifo_count), 32'd4);
    check_val("rst_pre_txd",   32'(TxD), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check_val("rst_mid_txd",   32'(TxD), 32'd1);
    check_val("rst_mid_count", 32'(fifo_count), 32'd0);
    check_val("rst_mid_busy",  32'(busy), 32'd0);
    check_val("rst_mid_ready", 32'(tx_ready), 32'd1);
    reset = 1'b0;
    lows = 0;
    repeat (300) begin
      @(negedge clk);
      if (TxD !== 1'b1) lows++;
    end
    check_val("rst_no_frame", 32'(lows), 32'd0);
    check_val("rst_after_busy", 32'(busy), 32'd0);

    // 5-bit instance, no parity: 5'b10011.
    parity_mode = 2'd0; two_stop = 1'b0;
    tx_data5 = 5'b10011; tx_valid5 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid5 = 1'b0;
    capture("w5", 1'b1, 7, 16'h0066, 1'b0);
    check_val("w5_end_busy",  32'(busy5), 32'd0);
    check_val("w5_end_count", 32'(fifo_count5), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz, SHALL be provided.
REQ-002 Parameter BAUD_RATE, default 115_200, line bit rate, SHALL be provided.
REQ-003 Parameter DATA_WIDTH, default 8, data bits per frame, legal range 5..9, SHALL be provided.
REQ-004 Parameter FIFO_DEPTH, default 16, transmit FIFO entries, power of two and >= 2, SHALL be provided.
REQ-005 Port clk, input, 1 bit, single clock; every register SHALL be updated on its rising edge.
REQ-006 Port reset, input, 1 bit, synchronous active-high reset, SHALL be provided.
REQ-007 Port tx_data, input, DATA_WIDTH bits, word to transmit, SHALL be provided.
REQ-008 Port tx_valid, input, 1 bit, tx_data is valid, SHALL be provided.
REQ-009 Port tx_ready, output, 1 bit, FIFO can accept a word, SHALL be provided.
REQ-010 Port parity_mode, input, 2 bits, 0 none / 1 even / 2 odd / 3 treated as none, SHALL be provided.
REQ-011 Port two_stop, input, 1 bit, 1 selects two stop bits, SHALL be provided.
REQ-012 Port TxD, output, 1 bit, serial line (idle high), SHALL be provided.
REQ-013 Port busy, output, 1 bit, a frame is in flight or the FIFO is non-empty, SHALL be provided.
REQ-014 Port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits, current FIFO occupancy, SHALL be provided.

Function
REQ-015 A word SHALL be written to the FIFO on a cycle where tx_valid && tx_ready; tx_ready SHALL equal !full.
REQ-016 On simultaneous push and pop, fifo_count SHALL be unchanged and both operations SHALL take effect.
REQ-017 CYCLES_PER_BIT SHALL equal CLK_FREQ/BAUD_RATE (integer division), and every line bit SHALL last exactly CYCLES_PER_BIT cycles.
REQ-018 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-019 IDLE -> START SHALL occur when the FIFO is non-empty; the head word SHALL be popped into a shift register, and parity_mode and two_stop SHALL be latched on that same cycle.
REQ-020 Configuration SHALL be held constant for the whole frame; input changes mid-frame SHALL affect only the next frame.
REQ-021 START SHALL drive TxD=0 for one bit period and then go to DATA.
REQ-022 DATA SHALL send DATA_WIDTH bits LSB-first; after the last bit it SHALL go to PARITY if the latched mode is even/odd, otherwise to STOP.
REQ-023 The parity bit SHALL be XOR of the data bits for even mode and its inverse for odd mode.
REQ-024 STOP SHALL drive TxD=1 for one bit period, or two bit periods if two_stop was latched.
REQ-025 At the end of STOP, a non-empty FIFO SHALL go to START on the next cycle, giving back-to-back frames with no idle gap; an empty FIFO SHALL go to IDLE.
REQ-026 With the FIFO empty and the FSM in IDLE, a word accepted on edge k SHALL produce TxD low starting at edge k+2.
REQ-027 busy SHALL be high whenever the state is not IDLE or fifo_count != 0.
REQ-028 A push when full SHALL be impossible by construction (tx_ready=0); data SHALL never be overwritten or lost.
REQ-029 Frame length SHALL be 1 + DATA_WIDTH + (parity?1:0) + (two_stop?2:1) bit periods.

Reset
REQ-030 Reset SHALL force state IDLE, TxD=1, busy=0, fifo_count=0, tx_ready=1, and zero the counters and pointers.
REQ-031 Reset asserted mid-frame SHALL abort the frame, discard all FIFO contents, and return TxD high on the next edge.

Structure
REQ-032 Package uart_pkg SHALL hold the FSM state enum, the parity_mode_e enum (PAR_NONE, PAR_EVEN, PAR_ODD), and the parity helper function.
REQ-033 The FIFO SHALL be a sub-module uart_fifo (parametrised width/depth, synchronous, count output).

Verification
REQ-034 CLK_FREQ=1_000_000, BAUD_RATE=100_000, even parity, one stop, push 0xA5 -> TxD 0,1,0,1,0,0,1,0,1, parity 0, stop 1, 10 cycles per bit, 11 bits total.
REQ-035 Odd parity, two stop, push 0x00 -> parity bit 1, TxD high for 20 cycles after parity, frame 12 bits.
REQ-036 Push 17 words back-to-back with FIFO_DEPTH=16 -> tx_ready low once count=16, no word lost, frames contiguous, busy low only after the final stop bit.
REQ-037 Change parity_mode from even to none during the DATA state -> current frame keeps its parity bit, next frame has none.
REQ-038 Assert reset during bit 3 of DATA with 4 words queued -> next edge TxD=1, fifo_count=0, busy=0, and no further frames.
REQ-039 DATA_WIDTH=5, no parity, push 5'b10011 -> TxD 0,1,1,0,0,1,1 (7 bits).
